// File: rtl/onehot_seq_decoder_pkg.sv
// onehot_seq_dec_pkg: shared FSM state type and width-generic decode helpers for onehot_seq_decoder
package onehot_seq_dec_pkg;

  typedef enum logic [1:0] {IDLE, SINGLE, SCAN} state_e;

  function automatic logic onehot(input int unsigned sel, input int unsigned i);
    return sel == i;
  endfunction

  function automatic logic thermometer(input int unsigned sel, input int unsigned i);
    return i <= sel;
  endfunction

endpackage

// File: rtl/onehot_seq_decoder_if.sv
// onehot_seq_decoder_if: command/result bundle; in_therm exists only with ONEHOT_SEQ_DECODER_THERM_EN
interface onehot_seq_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_mode;
  logic [DWELL_W-1:0]    in_dwell;
`ifdef ONEHOT_SEQ_DECODER_THERM_EN
  logic                  in_therm;
`endif
  logic                  abort;
  logic [(1<<SEL_W)-1:0] res;
  logic                  res_valid;
  logic                  done;

  modport master (
    output in_valid, in_sel, in_mode, in_dwell, abort,
`ifdef ONEHOT_SEQ_DECODER_THERM_EN
    output in_therm,
`endif
    input  in_ready, res, res_valid, done
  );

  modport slave (
    input  in_valid, in_sel, in_mode, in_dwell, abort,
`ifdef ONEHOT_SEQ_DECODER_THERM_EN
    input  in_therm,
`endif
    output in_ready, res, res_valid, done
  );

endinterface

// File: rtl/onehot_seq_decoder_core.sv
// onehot_dec_core: combinational index decoder producing a one-hot or thermometer vector
module onehot_dec_core
  import onehot_seq_dec_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  therm,
  output logic [(1<<SEL_W)-1:0] res
);

  for (genvar i = 0; i < (1 << SEL_W); i++) begin : g_bit
    assign res[i] = therm ? thermometer(32'(sel), i) : onehot(32'(sel), i);
  end

endmodule

// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder: registered decoder strobing one line (SINGLE) or scanning all lines (SCAN); ONEHOT_SEQ_DECODER_THERM_EN adds thermometer output
module onehot_seq_decoder
  import onehot_seq_dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  onehot_seq_decoder_if.slave bus
);

  localparam int OUT_W = 1 << SEL_W;

  state_e             state, state_n;
  logic [SEL_W-1:0]   idx, idx_n, scnt, scnt_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n, dcnt, dcnt_n;
  logic               therm_r, therm_n, therm_in, done_n, pos_end, accept;
  logic [OUT_W-1:0]   dec, res_n;

`ifdef ONEHOT_SEQ_DECODER_THERM_EN
  assign therm_in = bus.in_therm;
`else
  assign therm_in = 1'b0;
`endif

  assign bus.in_ready  = state == IDLE;
  assign bus.res_valid = |bus.res;
  assign pos_end       = dcnt == dwell_r;
  assign accept        = bus.in_valid & bus.in_ready & ~bus.abort;

  onehot_dec_core #(.SEL_W(SEL_W)) u_core (
    .sel   (idx_n),
    .therm (therm_n),
    .res   (dec)
  );

  // next-state and next-output computation; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_n = state;
    idx_n   = idx;
    scnt_n  = scnt;
    dwell_n = dwell_r;
    therm_n = therm_r;
    dcnt_n  = dcnt + 1'b1;
    if (bus.abort) begin
      state_n = IDLE;
      dcnt_n  = '0;
      scnt_n  = '0;
    end else if (state == IDLE) begin
      dcnt_n = '0;
      scnt_n = '0;
      if (accept) begin
        state_n = bus.in_mode ? SCAN : SINGLE;
        idx_n   = bus.in_sel;
        dwell_n = bus.in_dwell;
        therm_n = therm_in;
      end
    end else if (pos_end) begin
      dcnt_n  = '0;
      state_n = (state == SINGLE || &scnt) ? IDLE : state;
      idx_n   = (state == SCAN) ? idx + 1'b1 : idx;
      scnt_n  = (state_n == IDLE) ? '0 : scnt + 1'b1;
    end
    res_n  = (state_n == IDLE) ? '0 : dec;
    done_n = state_n != IDLE && dcnt_n == dwell_n && (state_n == SINGLE || &scnt_n);
  end

  // state, counters and output register; async reset drops the strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      scnt     <= '0;
      dwell_r  <= '0;
      dcnt     <= '0;
      therm_r  <= 1'b0;
      bus.res  <= '0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      scnt     <= scnt_n;
      dwell_r  <= dwell_n;
      dcnt     <= dcnt_n;
      therm_r  <= therm_n;
      bus.res  <= res_n;
      bus.done <= done_n;
    end
  end

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// tb_onehot_seq_decoder: table vectors, directed corner sequences and random commands against a position-list model
module tb_onehot_seq_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onehot_seq_decoder_if #(.SEL_W(3), .DWELL_W(8)) bus();

  onehot_seq_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int         sel;
    int         mode;
    int         dwell;
    logic [7:0] first;
    logic [7:0] last;
    int         cycles;
  } vec_t;

  vec_t vt[5];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int sel, input int mode, input int dwell);
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'(sel);
    bus.in_mode  = mode[0];
    bus.in_dwell = 8'(dwell);
  endtask

  task automatic run_cmd(input int sel, input int mode, input int dwell, input int hold);
    int npos;
    logic [7:0] e;
    logic last;
    issue(sel, mode, dwell);
    tick();
    npos = mode != 0 ? 8 : 1;
    bus.in_valid = hold[0];
    bus.in_sel   = 3'(sel + 3);
    bus.in_mode  = ~mode[0];
    bus.in_dwell = 8'(dwell + 5);
    for (int p = 0; p < npos; p++) begin
      for (int d = 0; d <= dwell; d++) begin
        e = 8'h01 << ((sel + p) % 8);
        last = (p == npos - 1) && (d == dwell);
        chk("res", 32'(bus.res), 32'(e));
        chk("res_valid", 32'(bus.res_valid), 1);
        chk("done", 32'(bus.done), 32'(last));
        chk("busy_ready", 32'(bus.in_ready), 0);
        if (last) bus.in_valid = 1'b0;
        tick();
      end
    end
    chk("idle_res", 32'(bus.res), 0);
    chk("idle_ready", 32'(bus.in_ready), 1);
    chk("idle_done", 32'(bus.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{5, 0, 0, 8'h20, 8'h20, 1};
    vt[1] = '{0, 0, 3, 8'h01, 8'h01, 4};
    vt[2] = '{6, 1, 1, 8'h40, 8'h20, 16};
    vt[3] = '{2, 1, 0, 8'h04, 8'h02, 8};
    vt[4] = '{7, 1, 4, 8'h80, 8'h40, 40};
    bus.in_valid = 1'b0;
    bus.in_sel   = '0;
    bus.in_mode  = 1'b0;
    bus.in_dwell = '0;
    bus.abort    = 1'b0;
`ifdef ONEHOT_SEQ_DECODER_THERM_EN
    bus.in_therm = 1'b0;
`endif
    #12;
    chk("rst_res", 32'(bus.res), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_res", 32'(bus.res), 0);
    chk("post_rst_done", 32'(bus.done), 0);
    chk("post_rst_valid", 32'(bus.res_valid), 0);

    for (int k = 0; k < 5; k++) begin
      issue(vt[k].sel, vt[k].mode, vt[k].dwell);
      tick();
      bus.in_valid = 1'b0;
      chk("vec_first", 32'(bus.res), 32'(vt[k].first));
      n = 1;
      while (!bus.done && n < 600) begin
        tick();
        n++;
      end
      chk("vec_len", n, vt[k].cycles);
      chk("vec_last", 32'(bus.res), 32'(vt[k].last));
      tick();
      chk("vec_idle", 32'(bus.res), 0);
    end

    run_cmd(5, 0, 0, 0);
    run_cmd(0, 0, 3, 1);
    tick();
    chk("not_queued", 32'(bus.res), 0);
    run_cmd(6, 1, 1, 0);
    issue(1, 0, 0);
    tick();
    chk("b2b_res", 32'(bus.res), 32'h02);
    chk("b2b_done", 32'(bus.done), 1);
    tick();
    chk("b2b_gap", 32'(bus.res), 0);
    tick();
    chk("b2b_second", 32'(bus.res), 32'h02);
    bus.in_valid = 1'b0;
    tick();

    issue(2, 1, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("ab_c1", 32'(bus.res), 32'h04);
    tick();
    chk("ab_c2", 32'(bus.res), 32'h08);
    tick();
    chk("ab_c3", 32'(bus.res), 32'h10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_res", 32'(bus.res), 0);
    chk("ab_done", 32'(bus.done), 0);
    chk("ab_ready", 32'(bus.in_ready), 1);
    tick();
    chk("ab_stay", 32'(bus.res), 0);

    issue(4, 0, 0);
    bus.abort = 1'b1;
    tick();
    chk("ab_idle_block", 32'(bus.res), 0);
    chk("ab_idle_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    tick();
    chk("ab_idle_stay", 32'(bus.res), 0);

    issue(1, 1, 2);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("ar_pre", 32'(bus.res), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_res", 32'(bus.res), 0);
    chk("ar_valid", 32'(bus.res_valid), 0);
    chk("ar_done", 32'(bus.done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_idle", 32'(bus.res), 0);
    run_cmd(3, 1, 0, 0);

`ifdef ONEHOT_SEQ_DECODER_THERM_EN
    issue(3, 0, 0);
    bus.in_therm = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_therm = 1'b0;
    chk("therm_res", 32'(bus.res), 32'h0F);
    chk("therm_done", 32'(bus.done), 1);
    tick();
    chk("therm_idle", 32'(bus.res), 0);
`endif

    for (int r = 0; r < 25; r++) begin
      run_cmd(int'($urandom_range(7)), int'($urandom_range(1)), int'($urandom_range(4)),
              int'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
